timer_mc_sb_ctrl: RTL and testbench

//  Multi-channel system-bus timer peripheral; generalises the single-channel timer to NUM_CH channels.
//  One shared free-running counter; per channel: delay, mode (OFF/NTIMES/FOREVER), repeat count.
//  Per-channel pending flags, an enable mask and one combined interrupt line to the core's IRQ controller.

---
 rtl/timer_mc_sb_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_timer_mc_sb_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mc_sb_ctrl.sv
// Multi-channel system-bus timer: one shared counter, per-channel OFF/NTIMES/FOREVER timers,
// W1C pending flags and a masked IRQ. Define TIMER_MC_PRESCALER_EN to add a tick prescaler at 0x10.
module timer_mc_sb_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        interrupt_request_o
);
  localparam int unsigned HiW = CNT_W - 32;

  typedef enum logic [1:0] {ModeOff = 2'd0, ModeNtimes = 2'd1, ModeForever = 2'd2} mode_e;

  logic [CNT_W-1:0]  counter_q, counter_d;
  logic [NUM_CH-1:0] pending_q, pending_d, enable_q, enable_d, fire, mode_wr;
  logic [CNT_W-1:0]  delay_q  [NUM_CH];
  logic [CNT_W-1:0]  delay_d  [NUM_CH];
  logic [CNT_W-1:0]  start_q  [NUM_CH];
  logic [CNT_W-1:0]  start_d  [NUM_CH];
  logic [CNT_W-1:0]  elapsed  [NUM_CH];
  mode_e             mode_q   [NUM_CH];
  mode_e             mode_d   [NUM_CH];
  logic [31:0]       repeat_q [NUM_CH];
  logic [31:0]       repeat_d [NUM_CH];
  logic [31:0]       remain_q [NUM_CH];
  logic [31:0]       remain_d [NUM_CH];
  logic              ready_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              tick, wr, soft_rst, ch_hit;
  logic [31:0]       ch_off, ch_idx;
  logic [4:0]        reg_off;

  assign wr       = req_i & write_enable_i;
  assign soft_rst = wr && (addr_i == 32'h24) && (write_data_i == 32'd1);
  assign ch_off   = addr_i - 32'h40;
  assign ch_idx   = {5'd0, ch_off[31:5]};
  assign reg_off  = ch_off[4:0];
  assign ch_hit   = (addr_i >= 32'h40) && (ch_idx < NUM_CH);

`ifdef TIMER_MC_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
  // Compare with >= so lowering the prescale mid-count cannot strand the divider.
  assign tick        = (presc_cnt_q >= prescale_q);
  assign presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
  assign prescale_d  = (wr && (addr_i == 32'h10)) ? write_data_i[15:0] : prescale_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst) begin
      prescale_q  <= '0;
      presc_cnt_q <= '0;
    end else begin
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A bus mode write on the same edge as a fire takes precedence and suppresses the fire.
  always_comb begin
    fire    = '0;
    mode_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elapsed[i] = counter_q - start_q[i];
      mode_wr[i] = wr && ch_hit && (ch_idx == 32'(i)) && (reg_off == 5'h08) &&
                   (write_data_i <= 32'd2);
      fire[i]    = tick && (mode_q[i] != ModeOff) && (elapsed[i] >= delay_q[i]) && !mode_wr[i];
    end
  end

  always_comb begin
    counter_d = tick ? counter_q + CNT_W'(1) : counter_q;
    pending_d = pending_q | fire;
    enable_d  = enable_q;
    if (wr && (addr_i == 32'h08)) pending_d = (pending_q & ~write_data_i[NUM_CH-1:0]) | fire;
    if (wr && (addr_i == 32'h0C)) enable_d = write_data_i[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      delay_d[i]  = delay_q[i];
      start_d[i]  = start_q[i];
      mode_d[i]   = mode_q[i];
      repeat_d[i] = repeat_q[i];
      remain_d[i] = remain_q[i];
      if (fire[i]) begin
        start_d[i] = counter_q;
        if (mode_q[i] == ModeNtimes) begin
          remain_d[i] = remain_q[i] - 32'd1;
          if (remain_q[i] == 32'd1) mode_d[i] = ModeOff;
        end
      end
      if (wr && ch_hit && (ch_idx == 32'(i))) begin
        case (reg_off)
          5'h00:   delay_d[i][31:0]       = write_data_i;
          5'h04:   delay_d[i][CNT_W-1:32] = write_data_i[HiW-1:0];
          5'h0C:   repeat_d[i]            = write_data_i;
          default: ;
        endcase
      end
      if (mode_wr[i]) begin
        start_d[i] = counter_q;
        case (write_data_i[1:0])
          2'd1: begin
            if (repeat_q[i] == 32'd0) begin
              mode_d[i] = ModeOff;
            end else begin
              mode_d[i]   = ModeNtimes;
              remain_d[i] = repeat_q[i];
            end
          end
          2'd2:    mode_d[i] = ModeForever;
          default: mode_d[i] = ModeOff;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (req_i && !write_enable_i) begin
      case (addr_i)
        32'h00:  rdata_d = counter_q[31:0];
        32'h04:  rdata_d = 32'(counter_q[CNT_W-1:32]);
        32'h08:  rdata_d = 32'(pending_q);
        32'h0C:  rdata_d = 32'(enable_q);
`ifdef TIMER_MC_PRESCALER_EN
        32'h10:  rdata_d = {16'd0, prescale_q};
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit && (ch_idx == 32'(i))) begin
          case (reg_off)
            5'h00:   rdata_d = delay_q[i][31:0];
            5'h04:   rdata_d = 32'(delay_q[i][CNT_W-1:32]);
            5'h08:   rdata_d = {30'd0, mode_q[i]};
            5'h0C:   rdata_d = repeat_q[i];
            5'h10:   rdata_d = remain_q[i];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= req_i;
      rdata_q <= rdata_d;
    end
    if (rst_i || soft_rst) begin
      counter_q <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_q[i]  <= '0;
        start_q[i]  <= '0;
        mode_q[i]   <= ModeOff;
        repeat_q[i] <= '0;
        remain_q[i] <= '0;
      end
    end else begin
      counter_q <= counter_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_q[i]  <= delay_d[i];
        start_q[i]  <= start_d[i];
        mode_q[i]   <= mode_d[i];
        repeat_q[i] <= repeat_d[i];
        remain_q[i] <= remain_d[i];
      end
    end
  end

  assign read_data_o         = rdata_q;
  assign ready_o             = ready_q;
  assign interrupt_request_o = |(pending_q & enable_q);

endmodule

// File: tb/tb_timer_mc_sb_ctrl.sv
// Bench for timer_mc_sb_ctrl: directed scenarios plus random bus traffic, every cycle checked
// against a transaction-level reference model of the register map and timer rules.
module tb_timer_mc_sb_ctrl;
  localparam int NumCh = 4;

  logic        clk = 1'b0;
  logic        rst_i, req_i, write_enable_i;
  logic [31:0] addr_i, write_data_i, read_data_o;
  logic        ready_o, interrupt_request_o;

  always #5 clk = ~clk;

  timer_mc_sb_ctrl #(.NUM_CH(NumCh), .CNT_W(64)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .req_i               (req_i),
    .write_enable_i      (write_enable_i),
    .addr_i              (addr_i),
    .write_data_i        (write_data_i),
    .read_data_o         (read_data_o),
    .ready_o             (ready_o),
    .interrupt_request_o (interrupt_request_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd;

  logic [63:0]      m_cnt;
  logic [63:0]      m_delay [NumCh];
  logic [63:0]      m_start [NumCh];
  int               m_mode  [NumCh];
  logic [31:0]      m_rep   [NumCh];
  logic [31:0]      m_rem   [NumCh];
  logic [NumCh-1:0] m_pend, m_en;
  logic             m_ready;
  logic [31:0]      m_rdata;
  logic [15:0]      m_presc, m_pcnt;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_cnt = '0; m_pend = '0; m_en = '0; m_presc = '0; m_pcnt = '0;
    for (int i = 0; i < NumCh; i++) begin
      m_delay[i] = '0; m_start[i] = '0; m_mode[i] = 0; m_rep[i] = '0; m_rem[i] = '0;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch, off;
    case (a)
      32'h00: return m_cnt[31:0];
      32'h04: return m_cnt[63:32];
      32'h08: return 32'(m_pend);
      32'h0C: return 32'(m_en);
`ifdef TIMER_MC_PRESCALER_EN
      32'h10: return {16'd0, m_presc};
`endif
      default: ;
    endcase
    if (a >= 32'h40 && a < 32'h40 + NumCh * 32) begin
      ch  = int'((a - 32'h40) / 32);
      off = int'((a - 32'h40) % 32);
      case (off)
        0:  return m_delay[ch][31:0];
        4:  return m_delay[ch][63:32];
        8:  return 32'(m_mode[ch]);
        12: return m_rep[ch];
        16: return m_rem[ch];
        default: ;
      endcase
    end
    return 32'd0;
  endfunction

  // One clock edge of the reference: fires use pre-edge state, then bus writes apply.
  task automatic m_step(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    logic [NumCh-1:0] fired;
    bit tick;
    int ch, off;
    m_ready = req;
    m_rdata = (req && !we) ? m_read(a) : 32'd0;
    if (req && we && a == 32'h24 && d == 32'd1) begin
      m_clear();
      return;
    end
    tick = 1'b1;
`ifdef TIMER_MC_PRESCALER_EN
    tick   = (m_pcnt >= m_presc);
    m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
`endif
    ch = -1; off = -1;
    if (a >= 32'h40 && a < 32'h40 + NumCh * 32) begin
      ch  = int'((a - 32'h40) / 32);
      off = int'((a - 32'h40) % 32);
    end
    fired = '0;
    for (int i = 0; i < NumCh; i++) begin
      bit mode_write = req && we && ch == i && off == 8 && d <= 32'd2;
      if (tick && m_mode[i] != 0 && (m_cnt - m_start[i]) >= m_delay[i] && !mode_write) begin
        fired[i]   = 1'b1;
        m_start[i] = m_cnt;
        if (m_mode[i] == 1) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) m_mode[i] = 0;
        end
      end
    end
    if (req && we) begin
      if (a == 32'h08) m_pend = m_pend & ~d[NumCh-1:0];
      if (a == 32'h0C) m_en = d[NumCh-1:0];
`ifdef TIMER_MC_PRESCALER_EN
      if (a == 32'h10) m_presc = d[15:0];
`endif
      if (ch >= 0) begin
        case (off)
          0:  m_delay[ch][31:0]  = d;
          4:  m_delay[ch][63:32] = d;
          12: m_rep[ch]          = d;
          8: begin
            m_start[ch] = m_cnt;
            if (d == 32'd1) begin
              if (m_rep[ch] == 0) m_mode[ch] = 0;
              else begin m_mode[ch] = 1; m_rem[ch] = m_rep[ch]; end
            end else if (d == 32'd2) m_mode[ch] = 2;
            else if (d == 32'd0) m_mode[ch] = 0;
          end
          default: ;
        endcase
      end
    end
    m_pend = m_pend | fired;
    if (tick) m_cnt = m_cnt + 1;
  endtask

  // Called at a falling edge: check outputs, drive the next request, advance the model.
  task automatic cycle(input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    check_eq("ready", 64'(ready_o), 64'(m_ready));
    if (m_ready) check_eq("rdata", 64'(read_data_o), 64'(m_rdata));
    check_eq("irq", 64'(interrupt_request_o), 64'(|(m_pend & m_en)));
    if (ready_o) last_rd = read_data_o;
    req_i = req; write_enable_i = we; addr_i = a; write_data_i = d;
    m_step(req, we, a, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    cycle(1'b1, 1'b0, a, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a, d;
      int r, ch;
      logic req, we;
      req = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 9) < 6);
      r   = $urandom_range(0, 9);
      d   = $urandom;
      case (r)
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10;
        5: begin a = 32'h24; d = ($urandom_range(0, 40) == 0) ? 32'd1 : 32'd0; end
        6: a = 32'h14;
        7: a = 32'h400;
        default: begin
          ch = $urandom_range(0, NumCh - 1);
          r  = $urandom_range(0, 5);
          a  = 32'h40 + 32'(ch) * 32'h20 + 32'(r) * 32'h4;
          case (r)
            0: d = $urandom_range(0, 12);
            1: d = ($urandom_range(0, 20) == 0) ? 32'd1 : 32'd0;
            2: d = $urandom_range(0, 3);
            3: d = $urandom_range(0, 4);
            default: ;
          endcase
        end
      endcase
      cycle(req, we, a, d);
    end
  endtask

  initial begin
    logic [31:0] r1, r2;
    int nev, last;
    rst_i = 1'b1; req_i = 1'b0; write_enable_i = 1'b0; addr_i = '0; write_data_i = '0;
    last_rd = '0;
    m_clear(); m_ready = 1'b0; m_rdata = '0;
    @(negedge clk); @(negedge clk);
    rst_i = 1'b0;

    // Counter reads four cycles apart.
    bus_rd(32'h00); r1 = last_rd;
    idle(2);
    bus_rd(32'h00); r2 = last_rd;
    check_eq("t1_cnt_diff", 64'(r2 - r1), 64'd4);

    // ch0 NTIMES x3, period 10.
    bus_wr(32'h40, 10); bus_wr(32'h4C, 3); bus_wr(32'h0C, 1); bus_wr(32'h48, 1);
    nev = 0; last = 0;
    for (int k = 0; k < 45; k++) begin
      if (interrupt_request_o) begin
        if (nev > 0) check_eq("t2_gap", 64'(k - last), 64'd10);
        nev++; last = k;
        bus_wr(32'h08, 1);
      end else idle(1);
    end
    check_eq("t2_events", 64'(nev), 64'd3);
    bus_rd(32'h48); check_eq("t2_mode", 64'(last_rd), 64'd0);
    bus_rd(32'h50); check_eq("t2_remain", 64'(last_rd), 64'd0);

    // ch1 FOREVER, clear, stop.
    bus_wr(32'h0C, 2); bus_wr(32'h60, 5); bus_wr(32'h68, 2);
    idle(12);
    bus_wr(32'h08, 2); bus_wr(32'h68, 0);
    idle(12);
    bus_rd(32'h08); check_eq("t3_quiet", 64'(last_rd), 64'd0);

    // ch3 (delay 8) and ch2 (delay 7) started one cycle apart fire together.
    bus_wr(32'h08, 32'hF); bus_wr(32'h0C, 4);
    bus_wr(32'hA0, 8); bus_wr(32'h80, 7);
    bus_wr(32'hA8, 2); bus_wr(32'h88, 2);
    idle(8);
    bus_rd(32'h08); check_eq("t4_pend", 64'(last_rd), 64'hC);
    check_eq("t4_irq", 64'(interrupt_request_o), 64'd1);
    bus_wr(32'h08, 4);
    idle(3);
    bus_wr(32'hA8, 0); bus_wr(32'h88, 0); bus_wr(32'h08, 32'hF);

    // W1C on the fire edge loses, then soft reset.
    bus_wr(32'h0C, 2); bus_wr(32'h68, 2);
    idle(4);
    bus_wr(32'h08, 2);
    bus_rd(32'h08); check_eq("t5_set_wins", 64'(last_rd & 32'h2), 64'h2);
    bus_wr(32'h24, 1);
    check_eq("t5_srst_irq", 64'(interrupt_request_o), 64'd0);
    bus_rd(32'h68); check_eq("t5_srst_mode", 64'(last_rd), 64'd0);
    bus_rd(32'h0C); check_eq("t5_srst_en", 64'(last_rd), 64'd0);

`ifdef TIMER_MC_PRESCALER_EN
    bus_wr(32'h10, 3);
    bus_rd(32'h00); r1 = last_rd;
    idle(2);
    bus_rd(32'h00); r2 = last_rd;
    check_eq("t6_cnt_diff", 64'(r2 - r1), 64'd1);
    bus_wr(32'h40, 2); bus_wr(32'h0C, 1); bus_wr(32'h48, 2);
    nev = 0; last = 0;
    for (int k = 0; k < 40; k++) begin
      if (interrupt_request_o) begin
        if (nev > 0) check_eq("t6_gap", 64'(k - last), 64'd8);
        nev++; last = k;
        bus_wr(32'h08, 1);
      end else idle(1);
    end
    check_eq("t6_events", 64'(nev >= 3), 64'd1);
    bus_wr(32'h24, 1);
`endif

    rand_phase(3000);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
